// File: rtl/dice_pkg.sv
// dice_pkg: shared die tables, FSM state type and helpers for the dice roll controller.
package dice_pkg;

  localparam logic [3:0] BLANK = 4'hF;

  localparam logic [2:0] DIE_D4   = 3'd0;
  localparam logic [2:0] DIE_D6   = 3'd1;
  localparam logic [2:0] DIE_D8   = 3'd2;
  localparam logic [2:0] DIE_D10  = 3'd3;
  localparam logic [2:0] DIE_D12  = 3'd4;
  localparam logic [2:0] DIE_D20  = 3'd5;
  localparam logic [2:0] DIE_D100 = 3'd6;

  localparam logic [6:0] SIDES [7] = '{7'd4, 7'd6, 7'd8, 7'd10, 7'd12, 7'd20, 7'd100};
  localparam logic [6:0] MASK  [7] = '{7'd3, 7'd7, 7'd7, 7'd15, 7'd15, 7'd31, 7'd127};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROLL,
    ST_SETTLE,
    ST_DRAW,
    ST_CONV,
    ST_SHOW
  } state_t;

  // Lowest set bit wins; returns 0 for an all-zero vector.
  function automatic logic [2:0] lowest_set(input logic [6:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 7; i > 0; i--) begin
      if (v[i-1]) idx = 3'(i - 1);
    end
    return idx;
  endfunction

  // Animation face value (1..100) to {tens, units}; tens blank below 10, 100 shows "00".
  function automatic logic [7:0] face_digits(input logic [6:0] v);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(v / 7'd10);
    u = 4'(v - {3'b000, t} * 7'd10);
    if (v < 7'd10) return {BLANK, u};
    return {(t == 4'd10) ? 4'd0 : t, u};
  endfunction

endpackage

// File: rtl/dice_bin2bcd.sv
// dice_bin2bcd: 7-bit binary to two BCD digits by repeated subtract-10.
//   clk, rst (sync, active-high), ena (freeze), start/bin in, done pulse, tens/units out.
//   tens reaches 10 for an input of 100.
module dice_bin2bcd (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       start,
  input  logic [6:0] bin,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] units
);

  logic       active;
  logic [6:0] rem;
  logic [3:0] tcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      rem    <= '0;
      tcnt   <= '0;
      done   <= 1'b0;
      tens   <= '0;
      units  <= '0;
    end else if (ena) begin
      done <= 1'b0;
      if (start) begin
        rem    <= bin;
        tcnt   <= '0;
        active <= 1'b1;
      end else if (active) begin
        if (rem >= 7'd10) begin
          rem  <= rem - 7'd10;
          tcnt <= tcnt + 4'd1;
        end else begin
          tens   <= tcnt;
          units  <= rem[3:0];
          done   <= 1'b1;
          active <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/dice_roll_controller.sv
// dice_roll_controller: arbitrates seven die buttons, animates, draws an unbiased
//   1..N value and presents it as BCD digit10/digit1 (4'hF = blank).
//   in : clk, rst (sync, active-high), ena, btn_raw[6:0], btn_active_high, rnd_in[7:0]
//   out: digit1, digit10, die_idx, busy, roll_done
//   ROLL_ANIM_EN: when defined, ROLL/SETTLE faces are shown on the digits.
module dice_roll_controller
  import dice_pkg::*;
#(
  parameter int unsigned ANIM_DIV     = 500000,
  parameter int unsigned SETTLE_STEPS = 6,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [6:0] btn_raw,
  input  logic       btn_active_high,
  input  logic [7:0] rnd_in,
  output logic [3:0] digit1,
  output logic [3:0] digit10,
  output logic [2:0] die_idx,
  output logic       busy,
  output logic       roll_done
);

  localparam int unsigned CNT_W    = $clog2(ANIM_DIV + 1);
  localparam int unsigned SETTLE_W = $clog2(SETTLE_STEPS + 1);

  // Button input path: polarity normalise, synchronise, edge detect (runs even when ena=0)
  logic [6:0] sync_q [SYNC_STAGES];
  logic [6:0] pressed;
  logic [6:0] pressed_d;
  logic [6:0] rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      pressed_d <= '0;
    end else begin
      sync_q[0] <= btn_raw ^ {7{~btn_active_high}};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      pressed_d <= pressed;
    end
  end

  assign pressed = sync_q[SYNC_STAGES-1];
  assign rise    = pressed & ~pressed_d;

  // FSM state and datapath registers
  state_t              state, state_n;
  logic [2:0]          die_n;
  logic [CNT_W-1:0]    step_cnt, step_n;
  logic [SETTLE_W-1:0] settle_cnt, settle_n;
  logic [6:0]          value, value_n;
  logic [3:0]          d1_n, d10_n;
  logic                done_n;
  logic                conv_start, start_n;

  logic                wrap;
  logic [7:0]          cand;
  logic                accept;

  logic                bcd_done;
  logic [3:0]          bcd_tens;
  logic [3:0]          bcd_units;

  dice_bin2bcd u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .start (conv_start),
    .bin   (value),
    .done  (bcd_done),
    .tens  (bcd_tens),
    .units (bcd_units)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      die_idx    <= '0;
      step_cnt   <= '0;
      settle_cnt <= '0;
      value      <= '0;
      digit1     <= BLANK;
      digit10    <= BLANK;
      roll_done  <= 1'b0;
      conv_start <= 1'b0;
    end else begin
      state      <= state_n;
      die_idx    <= die_n;
      step_cnt   <= step_n;
      settle_cnt <= settle_n;
      value      <= value_n;
      digit1     <= d1_n;
      digit10    <= d10_n;
      roll_done  <= done_n;
      conv_start <= start_n;
    end
  end

  always_comb begin
    state_n  = state;
    die_n    = die_idx;
    step_n   = step_cnt;
    settle_n = settle_cnt;
    value_n  = value;
    d1_n     = digit1;
    d10_n    = digit10;
    done_n   = roll_done;
    start_n  = conv_start;

    wrap   = (step_cnt == CNT_W'(ANIM_DIV - 1));
    cand   = rnd_in & {1'b0, MASK[die_idx]};
    accept = (cand < {1'b0, SIDES[die_idx]});

    if (ena) begin
      done_n  = 1'b0;
      start_n = 1'b0;
      case (state)
        ST_IDLE, ST_SHOW: begin
          if (|rise) begin
            state_n  = ST_ROLL;
            die_n    = lowest_set(rise);
            step_n   = '0;
            settle_n = '0;
            d1_n     = BLANK;
            d10_n    = BLANK;
          end
        end
        ST_ROLL: begin
          if (!pressed[die_idx]) begin
            state_n  = ST_SETTLE;
            step_n   = '0;
            settle_n = '0;
          end else if (wrap) begin
            step_n = '0;
`ifdef ROLL_ANIM_EN
            if (accept) {d10_n, d1_n} = face_digits(cand[6:0] + 7'd1);
`endif
          end else begin
            step_n = step_cnt + CNT_W'(1);
          end
        end
        ST_SETTLE: begin
          if (wrap) begin
            step_n = '0;
`ifdef ROLL_ANIM_EN
            if (accept) {d10_n, d1_n} = face_digits(cand[6:0] + 7'd1);
`endif
            if (settle_cnt == SETTLE_W'(SETTLE_STEPS - 1)) state_n = ST_DRAW;
            else settle_n = settle_cnt + SETTLE_W'(1);
          end else begin
            step_n = step_cnt + CNT_W'(1);
          end
        end
        ST_DRAW: begin
          if (accept) begin
            value_n = cand[6:0] + 7'd1;
            start_n = 1'b1;
            state_n = ST_CONV;
          end
        end
        ST_CONV: begin
          if (bcd_done) begin
            state_n = ST_SHOW;
            d1_n    = bcd_units;
            // tens of 10 only occurs for a d100 roll of 100, displayed as "00"
            d10_n   = (bcd_tens == 4'd0)  ? BLANK :
                      (bcd_tens == 4'd10) ? 4'd0  : bcd_tens;
            done_n  = 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE) && (state != ST_SHOW);

endmodule
